// File: rtl/sec_countdown_pkg.sv
// Shared types and helpers for the minutes:seconds countdown timer.
// Optional build macro used by the top: SEC_COUNTDOWN_AUTO_RELOAD_EN.
package sec_countdown_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam int unsigned SEC_MAX         = 59;
    localparam int unsigned MAX_MIN_DEFAULT = 59;

    // Saturate a preset value to the largest legal value of its digit.
    function automatic int unsigned clamp_val(input int unsigned value,
                                              input int unsigned limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/sec_down_digit.sv
// One down-counting time digit pair (0..LIMIT) with enable, load and a
// registered borrow-out that pulses for one cycle when the value wraps 0->LIMIT.
module sec_down_digit #(
    parameter int unsigned LIMIT = 59,
    parameter int unsigned W     = 6
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         borrow
);

    // Load has priority over counting; borrow is only raised on a wrap.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            value  <= '0;
            borrow <= 1'b0;
        end else if (load) begin
            value  <= load_val;
            borrow <= 1'b0;
        end else if (en) begin
            if (value == '0) begin
                value  <= W'(LIMIT);
                borrow <= 1'b1;
            end else begin
                value  <= value - W'(1);
                borrow <= 1'b0;
            end
        end else begin
            borrow <= 1'b0;
        end
    end

endmodule

// File: rtl/sec_countdown.sv
// Minutes:seconds countdown timer with IDLE/RUNNING/PAUSED/EXPIRED control.
// Build option: define SEC_COUNTDOWN_AUTO_RELOAD_EN to reload the preset and
// keep running when the count reaches 00:00 instead of expiring.
module sec_countdown
    import sec_countdown_pkg::*;
#(
    parameter int unsigned MAX_MIN = MAX_MIN_DEFAULT,
    parameter int unsigned SEC_W   = 6
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             tick,
    input  logic             load,
    input  logic [SEC_W-1:0] load_min,
    input  logic [SEC_W-1:0] load_sec,
    input  logic             start,
    input  logic             pause,
    output logic [SEC_W-1:0] OutSec,
    output logic [SEC_W-1:0] OutMin,
    output logic             borrowSec,
    output logic             running,
    output logic             expired,
    output logic             expiredPulse
);

    state_t           state;
    state_t           state_next;
    logic [SEC_W-1:0] preset_sec;
    logic [SEC_W-1:0] preset_min;
    logic [SEC_W-1:0] clamp_sec;
    logic [SEC_W-1:0] clamp_min;
    logic [SEC_W-1:0] digit_sec_val;
    logic [SEC_W-1:0] digit_min_val;
    logic             count_zero;
    logic             preset_zero;
    logic             at_one;
    logic             dec;
    logic             reload;
    logic             expire_evt;
    logic             digit_load;
    logic             min_borrow_unused;

    assign clamp_sec   = SEC_W'(clamp_val(32'(load_sec), SEC_MAX));
    assign clamp_min   = SEC_W'(clamp_val(32'(load_min), MAX_MIN));
    assign count_zero  = (OutSec == '0) && (OutMin == '0);
    assign preset_zero = (preset_sec == '0) && (preset_min == '0);
    assign at_one      = (OutMin == '0) && (OutSec == SEC_W'(1));

    // A fresh load overrides any preset reload on the same edge.
    assign digit_load    = load | reload;
    assign digit_sec_val = load ? clamp_sec : preset_sec;
    assign digit_min_val = load ? clamp_min : preset_min;

    // State register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= IDLE;
        else         state <= state_next;
    end

    // Next state plus per-cycle count controls; load > start/pause > tick.
    always_comb begin
        state_next = state;
        dec        = 1'b0;
        reload     = 1'b0;
        expire_evt = 1'b0;
        if (load) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !count_zero) state_next = RUNNING;
                end
                RUNNING: begin
                    if (pause) begin
                        state_next = PAUSED;
                    end else if (tick) begin
                        if (at_one) begin
                            expire_evt = 1'b1;
`ifdef SEC_COUNTDOWN_AUTO_RELOAD_EN
                            if (!preset_zero) reload = 1'b1;
                            else              state_next = EXPIRED;
`else
                            state_next = EXPIRED;
`endif
                        end
                        dec = !reload;
                    end
                end
                PAUSED: begin
                    if (start) state_next = RUNNING;
                end
                EXPIRED: begin
                    if (start && !preset_zero) begin
                        state_next = RUNNING;
                        reload     = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Preset registers capture the clamped load values for later restarts.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            preset_sec <= '0;
            preset_min <= '0;
        end else if (load) begin
            preset_sec <= clamp_sec;
            preset_min <= clamp_min;
        end
    end

    // One-cycle pulse marking the tick that reached 00:00.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) expiredPulse <= 1'b0;
        else         expiredPulse <= expire_evt;
    end

    assign running = (state == RUNNING);
    assign expired = (state == EXPIRED);

    sec_down_digit #(
        .LIMIT (SEC_MAX),
        .W     (SEC_W)
    ) u_sec (
        .clk      (clk),
        .resetN   (resetN),
        .en       (dec),
        .load     (digit_load),
        .load_val (digit_sec_val),
        .value    (OutSec),
        .borrow   (borrowSec)
    );

    sec_down_digit #(
        .LIMIT (MAX_MIN),
        .W     (SEC_W)
    ) u_min (
        .clk      (clk),
        .resetN   (resetN),
        .en       (dec && (OutSec == '0)),
        .load     (digit_load),
        .load_val (digit_min_val),
        .value    (OutMin),
        .borrow   (min_borrow_unused)
    );

endmodule

// File: tb/tb_sec_countdown.sv
// Directed table-driven bench for sec_countdown; each vector is one clock.
module tb_sec_countdown;

    localparam int W = 7;

    logic         clk;
    logic         resetN;
    logic         tick;
    logic         load;
    logic [W-1:0] load_min;
    logic [W-1:0] load_sec;
    logic         start;
    logic         pause;
    logic [W-1:0] OutSec;
    logic [W-1:0] OutMin;
    logic         borrowSec;
    logic         running;
    logic         expired;
    logic         expiredPulse;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic ld;
        int   lm;
        int   ls;
        logic st;
        logic pa;
        logic tk;
        int   em;
        int   es;
        logic eb;
        logic er;
        logic ee;
        logic ep;
    } vec_t;

    vec_t vecs[$];

    sec_countdown #(
        .MAX_MIN (59),
        .SEC_W   (W)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .tick         (tick),
        .load         (load),
        .load_min     (load_min),
        .load_sec     (load_sec),
        .start        (start),
        .pause        (pause),
        .OutSec       (OutSec),
        .OutMin       (OutMin),
        .borrowSec    (borrowSec),
        .running      (running),
        .expired      (expired),
        .expiredPulse (expiredPulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic ld, input int lm, input int ls,
                       input logic st, input logic pa, input logic tk,
                       input int em, input int es, input logic eb,
                       input logic er, input logic ee, input logic ep);
        vec_t v;
        v.ld = ld; v.lm = lm; v.ls = ls; v.st = st; v.pa = pa; v.tk = tk;
        v.em = em; v.es = es; v.eb = eb; v.er = er; v.ee = ee; v.ep = ep;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int em, input int es,
                         input logic eb, input logic er, input logic ee,
                         input logic ep);
        checks++;
        if (OutMin !== W'(em) || OutSec !== W'(es) || borrowSec !== eb ||
            running !== er || expired !== ee || expiredPulse !== ep) begin
            errors++;
            $display("FAIL %s: got %0d:%0d bor=%b run=%b exp=%b pul=%b, want %0d:%0d bor=%b run=%b exp=%b pul=%b",
                     name, OutMin, OutSec, borrowSec, running, expired, expiredPulse,
                     em, es, eb, er, ee, ep);
        end
    endtask

    task automatic drive(input logic ld, input int lm, input int ls,
                         input logic st, input logic pa, input logic tk);
        @(negedge clk);
        load = ld; load_min = W'(lm); load_sec = W'(ls);
        start = st; pause = pa; tick = tk;
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetN = 1'b0;
        tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
        load_min = '0; load_sec = '0;

        //    ld lm  ls  st pa tk   em  es  eb er ee ep
        add(1, 1,  2,  0, 0, 0,   1,  2,  0, 0, 0, 0);
        add(0, 0,  0,  1, 0, 0,   1,  2,  0, 1, 0, 0);
        add(0, 0,  0,  0, 0, 1,   1,  1,  0, 1, 0, 0);
        add(0, 0,  0,  0, 0, 1,   1,  0,  0, 1, 0, 0);
        add(0, 0,  0,  0, 0, 1,   0, 59,  1, 1, 0, 0);
        add(0, 0,  0,  0, 0, 0,   0, 59,  0, 1, 0, 0);
        add(1, 0,  2,  0, 0, 0,   0,  2,  0, 0, 0, 0);
        add(0, 0,  0,  0, 0, 1,   0,  2,  0, 0, 0, 0);
        add(0, 0,  0,  1, 0, 0,   0,  2,  0, 1, 0, 0);
        add(0, 0,  0,  0, 0, 1,   0,  1,  0, 1, 0, 0);
`ifdef SEC_COUNTDOWN_AUTO_RELOAD_EN
        add(0, 0,  0,  0, 0, 1,   0,  2,  0, 1, 0, 1);
        add(0, 0,  0,  0, 0, 1,   0,  1,  0, 1, 0, 0);
        add(0, 0,  0,  0, 0, 1,   0,  2,  0, 1, 0, 1);
        add(0, 0,  0,  0, 1, 0,   0,  2,  0, 0, 0, 0);
`else
        add(0, 0,  0,  0, 0, 1,   0,  0,  0, 0, 1, 1);
        add(0, 0,  0,  0, 0, 1,   0,  0,  0, 0, 1, 0);
        add(0, 0,  0,  0, 0, 1,   0,  0,  0, 0, 1, 0);
        add(0, 0,  0,  0, 1, 0,   0,  0,  0, 0, 1, 0);
`endif
        add(0, 0,  0,  1, 0, 0,   0,  2,  0, 1, 0, 0);
        add(0, 0,  0,  0, 0, 1,   0,  1,  0, 1, 0, 0);
        add(1, 0, 10,  0, 0, 0,   0, 10,  0, 0, 0, 0);
        add(0, 0,  0,  1, 0, 0,   0, 10,  0, 1, 0, 0);
        add(0, 0,  0,  0, 1, 1,   0, 10,  0, 0, 0, 0);
        for (int k = 0; k < 5; k++)
            add(0, 0, 0, 0, 0, 1, 0, 10, 0, 0, 0, 0);
        add(0, 0,  0,  1, 0, 0,   0, 10,  0, 1, 0, 0);
        add(0, 0,  0,  0, 0, 1,   0,  9,  0, 1, 0, 0);
        add(0, 0,  0,  1, 1, 0,   0,  9,  0, 0, 0, 0);
        add(0, 0,  0,  1, 0, 1,   0,  9,  0, 1, 0, 0);
        add(1, 75, 80, 0, 0, 1,  59, 59,  0, 0, 0, 0);
        add(0, 0,  0,  1, 0, 0,  59, 59,  0, 1, 0, 0);
        add(0, 0,  0,  0, 0, 1,  59, 58,  0, 1, 0, 0);
        add(1, 0,  0,  0, 0, 0,   0,  0,  0, 0, 0, 0);
        add(0, 0,  0,  1, 0, 0,   0,  0,  0, 0, 0, 0);
        add(1, 1,  0,  0, 0, 0,   1,  0,  0, 0, 0, 0);
        add(0, 0,  0,  1, 0, 0,   1,  0,  0, 1, 0, 0);
        add(0, 0,  0,  0, 0, 1,   0, 59,  1, 1, 0, 0);
        add(1, 3,  0,  0, 0, 1,   3,  0,  0, 0, 0, 0);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        resetN = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].ld, vecs[i].lm, vecs[i].ls,
                  vecs[i].st, vecs[i].pa, vecs[i].tk);
            check($sformatf("vec%0d", i), vecs[i].em, vecs[i].es,
                  vecs[i].eb, vecs[i].er, vecs[i].ee, vecs[i].ep);
        end

        // Asynchronous reset while counting from 02:30.
        drive(1, 2, 30, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        check("run_0230", 2, 30, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1);
        check("run_0229", 2, 29, 0, 1, 0, 0);
        @(negedge clk);
        tick = 1'b0; start = 1'b0;
        #2;
        resetN = 1'b0;
        #1;
        check("async_reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        resetN = 1'b1;
        drive(0, 0, 0, 1, 0, 1);
        check("no_resume_after_reset", 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sec_countdown.md
Name: sec_countdown

Overview:
- Minutes:seconds down-counter for timer mode. It is the decrementing counterpart of the seconds/minutes increment chain.
- Seconds count down on a 1 Hz tick enable. When seconds wrap from 0 to 59, the block issues a one-cycle borrow and decrements minutes.
- Block-level FSM (IDLE/RUNNING/PAUSED/EXPIRED) provides start, pause, load and expiry.
- Sits between the tick prescaler and the 7-segment display mux.

Parameters:
- MAX_MIN, 59, largest loadable minute value; load values above it clamp to MAX_MIN.
- SEC_W, 6, seconds/minutes output width; must hold 59 and MAX_MIN.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- resetN  input  1  reset, asynchronous, active-low.
- tick  input  1  one-cycle 1 Hz enable from prescaler.
- load  input  1  latch load_min/load_sec as the new count and preset.
- load_min  input  SEC_W  minutes preset.
- load_sec  input  SEC_W  seconds preset.
- start  input  1  start (from IDLE) or resume (from PAUSED); one-cycle pulse.
- pause  input  1  pause while RUNNING; one-cycle pulse.
- OutSec  output  SEC_W  current seconds, 0..59.
- OutMin  output  SEC_W  current minutes, 0..MAX_MIN.
- borrowSec  output  1  one-cycle pulse when seconds wrap 0->59.
- running  output  1  high in RUNNING.
- expired  output  1  level; high in EXPIRED.
- expiredPulse  output  1  one-cycle pulse on entry to EXPIRED.

Behaviour:
- Reset (resetN=0, async): state=IDLE, OutSec=0, OutMin=0, preset=00:00, all flags 0. Reset mid-count aborts immediately; there is no resume after reset.
- Load clamping: sec>59 -> 59; min>MAX_MIN -> MAX_MIN.
- Priority per cycle: load > start/pause > tick.
- load, any state: count and preset take the clamped values next cycle; state=IDLE; borrowSec and expiredPulse are not asserted. A tick in the same cycle is ignored.
- IDLE:
  - start with count != 00:00 -> RUNNING next cycle.
  - start with count == 00:00 is ignored.
  - tick is ignored.
- RUNNING:
  - On tick with sec>0: sec <= sec-1.
  - On tick with sec==0 and min>0: sec <= 59, min <= min-1, borrowSec=1 in the same cycle the outputs update (registered, 1-cycle).
  - If a tick makes the count 00:00: state=EXPIRED; expiredPulse=1 for exactly one cycle; expired=1 from the same edge.
  - pause -> PAUSED; count frozen. pause and tick in the same cycle: pause wins, no decrement.
- PAUSED:
  - tick is ignored.
  - start -> RUNNING; the first decrement happens on the next tick after resuming.
- EXPIRED:
  - Count holds 00:00; tick and pause are ignored.
  - start -> reload preset and go to RUNNING (restart), provided preset != 00:00.
- Latency: tick to output update is 1 clk. Outputs are registered, with no combinational path from inputs.
- Boundaries:
  - 00:01 -> EXPIRED with no borrow.
  - 01:00 -> 00:59 with borrow.
  - Load 00:00 then start: stays IDLE.
  - start and pause in the same cycle while RUNNING: pause wins.

Optional Feature:
- Macro: SEC_COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - On the tick reaching 00:00, expiredPulse fires, the count reloads the preset on the same edge, and the block stays RUNNING.
  - expired level stays 0.
  - A preset of 00:00 still goes to EXPIRED.
- Undefined: behaviour as above.

Decomposition:
- Shared package: state enum (IDLE, RUNNING, PAUSED, EXPIRED), SEC_MAX=59, default MAX_MIN, clamp function.
- One natural sub-module: sec_down_digit, a 0..59 down-counter with enable, load and borrow-out. It is instantiated twice (seconds; minutes with limit MAX_MIN, borrow unused). The FSM stays in the top.

Test Plan:
- Reset mid-RUNNING at 02:30 -> OutMin=0, OutSec=0, state IDLE, all flags 0 asynchronously.
- load 01:02, start, 3 ticks -> 01:01, 01:00, 00:59; borrowSec pulses exactly on the third tick.
- load 00:02, start, 2 ticks -> 00:01, then 00:00 with expiredPulse for 1 cycle and expired=1; further ticks hold 00:00.
- RUNNING at 00:10, pause with tick in the same cycle -> stays 00:10; 5 ticks no change; start then 1 tick -> 00:09.
- load 75:80 with MAX_MIN=59 -> 59:59. Load 00:00 then start -> remains IDLE, running=0.
- With SEC_COUNTDOWN_AUTO_RELOAD_EN: load 00:02, start, 4 ticks -> 00:01, 00:02 (pulse), 00:01, 00:02 (pulse); expired stays 0.
